// File: rtl/program_loader_pkg.sv
// Shared types for the program loader: FSM states, header size and word type.
package program_loader_pkg;

   typedef logic [31:0] word;

   localparam int LOADER_LEN_BYTES = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERROR
   } loader_state_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs four stream bytes into a little-endian word.
// Pulses word_ready with the completed word on the 4th byte.
module word_assembler
   import program_loader_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   input  logic       byte_en,
   input  logic [7:0] byte_data,
   output logic       word_ready,
   output word        word_out
);

   logic [1:0] cnt_q;
   word        sh_q;

   // Completed word is visible combinationally alongside the 4th byte
   assign word_ready = byte_en & (cnt_q == 2'd3);
   assign word_out   = {byte_data, sh_q[31:8]};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         sh_q  <= '0;
      end else if (clear) begin
         cnt_q <= '0;
         sh_q  <= '0;
      end else if (byte_en) begin
         cnt_q <= cnt_q + 2'd1;
         sh_q  <= word_out;
      end
   end

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed, checksummed program image into instruction
// memory while holding the core in reset.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int WORDS  = 256,
   parameter int ADDR_W = $clog2(WORDS)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output word               imem_wdata,
   output logic              core_hold,
   output logic              busy,
   output logic              done,
   output logic              error
);

   loader_state_t     state_q, state_nx;
   logic [15:0]       len_q;
   logic [ADDR_W-1:0] idx_q;
   logic [7:0]        csum_q;
   logic              accept;
   logic              start_ok;
   logic              in_data;
   logic              word_ready;
   word               asm_word;
   logic [15:0]       len_full;
   logic              overflow;
   logic              last_word;

   assign accept    = byte_valid & byte_ready;
   assign in_data   = (state_q == S_DATA) & accept;
   assign start_ok  = start & ((state_q == S_IDLE) |
                               (state_q == S_DONE) |
                               (state_q == S_ERROR));
   assign len_full  = {byte_data, len_q[7:0]};
   assign overflow  = len_full > 16'(WORDS);
   assign last_word = 16'(idx_q) == (len_q - 16'd1);

   word_assembler u_asm (
      .clock      (clock),
      .reset      (reset),
      .clear      (start_ok),
      .byte_en    (in_data),
      .byte_data  (byte_data),
      .word_ready (word_ready),
      .word_out   (asm_word)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_nx;
   end

   always_comb begin
      state_nx   = state_q;
      byte_ready = 1'b0;
      busy       = 1'b0;
      core_hold  = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            done = (state_q == S_DONE);
            if (start) state_nx = S_LEN_LO;
         end
         S_ERROR: begin
            error     = 1'b1;
            core_hold = 1'b1;
            if (start) state_nx = S_LEN_LO;
         end
         S_LEN_LO: begin
            byte_ready = 1'b1;
            if (byte_valid) state_nx = S_LEN_HI;
         end
         S_LEN_HI: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               if (overflow)            state_nx = S_ERROR;
               else if (len_full == '0) state_nx = S_CSUM;
               else                     state_nx = S_DATA;
            end
         end
         S_DATA: begin
            byte_ready = 1'b1;
            if (word_ready && last_word) state_nx = S_CSUM;
         end
         S_CSUM: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               if (byte_data == csum_q) state_nx = S_DONE;
               else                     state_nx = S_ERROR;
            end
         end
         default: state_nx = S_IDLE;
      endcase
      if (byte_ready) begin
         busy      = 1'b1;
         core_hold = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         len_q      <= '0;
         idx_q      <= '0;
         csum_q     <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         imem_we <= word_ready;
         if (word_ready) begin
            imem_addr  <= idx_q;
            imem_wdata <= asm_word;
         end
         if (start_ok) begin
            idx_q  <= '0;
            csum_q <= '0;
         end else if (state_q == S_LEN_LO && accept) begin
            len_q[7:0] <= byte_data;
         end else if (state_q == S_LEN_HI && accept) begin
            len_q <= len_full;
         end else if (in_data) begin
            csum_q <= csum_q + byte_data;
            if (word_ready) idx_q <= idx_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a byte-level model predicts
// each instruction-memory write as the stream is driven.
module tb_program_loader;

   typedef logic [7:0] byte_q_t[$];

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = '0;
   logic        byte_ready;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        core_hold;
   logic        busy;
   logic        done;
   logic        error;

   int n_chk  = 0;
   int n_pass = 0;
   int gap_max = 0;
   int start_at = -1;
   logic [39:0] exp_q[$];

   program_loader #(.WORDS(256)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_hold  (core_hold),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [39:0] got,
                      input logic [39:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   always @(negedge clock) begin
      if (imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", {imem_addr, imem_wdata}, 40'h0);
         end else begin
            logic [39:0] e;
            e = exp_q.pop_front();
            chk("write", {imem_addr, imem_wdata}, e);
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_ready"}, 40'(byte_ready), 40'd0);
      chk({tag, "_busy"},  40'(busy),       40'd0);
      chk({tag, "_we"},    40'(imem_we),    40'd0);
      chk({tag, "_addr"},  40'(imem_addr),  40'd0);
      chk({tag, "_wdata"}, 40'(imem_wdata), 40'd0);
      chk({tag, "_hold"},  40'(core_hold),  40'd0);
      chk({tag, "_done"},  40'(done),       40'd0);
      chk({tag, "_error"}, 40'(error),      40'd0);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      chk("start_ready", 40'(byte_ready), 40'd1);
      chk("start_busy",  40'(busy),       40'd1);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      repeat ($urandom_range(0, gap_max)) begin
         @(posedge clock); #1;
      end
      byte_valid = 1'b1;
      byte_data  = b;
      @(negedge clock);
      while (!byte_ready && t < 50) begin
         @(negedge clock);
         t++;
      end
      if (!byte_ready) chk("ready_timeout", 40'(byte_ready), 40'd1);
      @(posedge clock); #1;
      byte_valid = 1'b0;
   endtask

   // Sends s[0..n-1]; pushes each write the stream implies before driving
   task automatic send_stream(input byte_q_t s, input int n);
      logic [15:0] len = '0;
      logic [31:0] w = '0;
      int idx = 0;
      for (int i = 0; i < n; i++) begin
         if (i == 0) len[7:0] = s[i];
         else if (i == 1) len[15:8] = s[i];
         else if (len <= 16'd256 && (i - 2) < 4 * int'(len)) begin
            w = {s[i], w[31:8]};
            if ((i - 2) % 4 == 3) begin
               exp_q.push_back({8'(idx), w});
               idx++;
            end
         end
         if (i == start_at) start = 1'b1;
         send_byte(s[i]);
         start = 1'b0;
      end
   endtask

   task automatic check_end(input string tag, input logic d,
                            input logic e, input logic h);
      chk({tag, "_done"},  40'(done),      40'(d));
      chk({tag, "_error"}, 40'(error),     40'(e));
      chk({tag, "_hold"},  40'(core_hold), 40'(h));
      chk({tag, "_busy"},  40'(busy),      40'd0);
      @(posedge clock); #1;
      chk({tag, "_pending"}, 40'(exp_q.size()), 40'd0);
   endtask

   byte_q_t good = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                     8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
   byte_q_t bad  = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                     8'h93, 8'h00, 8'h10, 8'h00, 8'hB7};
   byte_q_t ovf  = '{8'h01, 8'h01};
   byte_q_t e_ok = '{8'h00, 8'h00, 8'h00};
   byte_q_t e_bd = '{8'h00, 8'h00, 8'h01};

   initial begin
      #1;
      check_reset_vals("por");
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      check_reset_vals("idle");

      do_start();
      send_stream(good, good.size());
      check_end("normal", 1'b1, 1'b0, 1'b0);

      do_start();
      send_stream(bad, bad.size());
      check_end("badsum", 1'b0, 1'b1, 1'b1);

      do_start();
      send_stream(ovf, ovf.size());
      chk("ovf_error", 40'(error),      40'd1);
      chk("ovf_ready", 40'(byte_ready), 40'd0);
      repeat (3) @(posedge clock);
      #1;
      check_end("ovf", 1'b0, 1'b1, 1'b1);

      do_start();
      send_stream(e_ok, e_ok.size());
      check_end("empty", 1'b1, 1'b0, 1'b0);

      do_start();
      send_stream(e_bd, e_bd.size());
      check_end("empty_bad", 1'b0, 1'b1, 1'b1);

      gap_max = 3;
      do_start();
      send_stream(good, good.size());
      check_end("gaps", 1'b1, 1'b0, 1'b0);
      gap_max = 0;

      do_start();
      send_stream(good, 7);
      reset = 1'b0;
      #1;
      check_reset_vals("midrst");
      @(posedge clock); #1;
      reset = 1'b1;
      exp_q.delete();
      @(posedge clock); #1;
      do_start();
      send_stream(good, good.size());
      check_end("after_rst", 1'b1, 1'b0, 1'b0);

      start_at = 5;
      do_start();
      send_stream(good, good.size());
      start_at = -1;
      check_end("mid_start", 1'b1, 1'b0, 1'b0);

      chk("pre_restart_done", 40'(done), 40'd1);
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      chk("restart_done", 40'(done), 40'd0);
      chk("restart_busy", 40'(busy), 40'd1);
      send_stream(good, good.size());
      check_end("restart", 1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
